// File: rtl/mc_datapath_pkg.sv
// Shared types and encodings for the multi-cycle datapath: FSM states,
// ALU control codes, funct/alu_op encodings and the ALU control decoder.
package mc_datapath_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_DECODE    = 3'd1,
    ST_EXECUTE   = 3'd2,
    ST_MEMORY    = 3'd3,
    ST_WRITEBACK = 3'd4
  } state_e;

  localparam logic [3:0] ALUCTL_AND = 4'b0000;
  localparam logic [3:0] ALUCTL_OR  = 4'b0001;
  localparam logic [3:0] ALUCTL_ADD = 4'b0010;
  localparam logic [3:0] ALUCTL_SUB = 4'b0110;
  localparam logic [3:0] ALUCTL_SLT = 4'b0111;
  localparam logic [3:0] ALUCTL_NOR = 4'b1100;
  localparam logic [3:0] ALUCTL_BAD = 4'b1111;

  localparam logic [5:0] FUNCT_ADD = 6'h20;
  localparam logic [5:0] FUNCT_SUB = 6'h22;
  localparam logic [5:0] FUNCT_AND = 6'h24;
  localparam logic [5:0] FUNCT_OR  = 6'h25;
  localparam logic [5:0] FUNCT_NOR = 6'h27;
  localparam logic [5:0] FUNCT_SLT = 6'h2A;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  typedef struct packed {
    logic [1:0] alu_op;
    logic [5:0] func_code;
    logic       reg_dst;
    logic       alu_src;
    logic       mem_write;
    logic       mem_read;
    logic       mem_to_reg;
    logic       reg_write;
  } ctrl_t;

  // Unknown funct or alu_op yields ALUCTL_BAD, which the ALU maps to 0.
  function automatic logic [3:0] alu_ctl_f(input logic [1:0] alu_op, input logic [5:0] funct);
    logic [3:0] ctl;
    case (alu_op)
      ALUOP_ADD: ctl = ALUCTL_ADD;
      ALUOP_SUB: ctl = ALUCTL_SUB;
      ALUOP_FUNCT: begin
        case (funct)
          FUNCT_ADD: ctl = ALUCTL_ADD;
          FUNCT_SUB: ctl = ALUCTL_SUB;
          FUNCT_AND: ctl = ALUCTL_AND;
          FUNCT_OR:  ctl = ALUCTL_OR;
          FUNCT_NOR: ctl = ALUCTL_NOR;
          FUNCT_SLT: ctl = ALUCTL_SLT;
          default:   ctl = ALUCTL_BAD;
        endcase
      end
      default: ctl = ALUCTL_BAD;
    endcase
    return ctl;
  endfunction

endpackage

// File: rtl/multicycle_datapath_if.sv
// Instruction/control bus of the multi-cycle datapath; master drives the
// decoded instruction, slave is the datapath.
interface multicycle_datapath_if #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
);
  logic              start;
  logic [REG_AW-1:0] rs;
  logic [REG_AW-1:0] rt;
  logic [REG_AW-1:0] rd;
  logic [15:0]       immediate;
  logic [5:0]        func_code;
  logic [1:0]        alu_op;
  logic              reg_dst;
  logic              alu_src;
  logic              mem_write;
  logic              mem_read;
  logic              mem_to_reg;
  logic              reg_write;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] result;
  logic              zero;
  logic [REG_AW-1:0] dbg_addr;
  logic [DATA_W-1:0] dbg_data;

  modport master (
    output start, rs, rt, rd, immediate, func_code, alu_op,
           reg_dst, alu_src, mem_write, mem_read, mem_to_reg, reg_write, dbg_addr,
    input  busy, done, result, zero, dbg_data
  );

  modport slave (
    input  start, rs, rt, rd, immediate, func_code, alu_op,
           reg_dst, alu_src, mem_write, mem_read, mem_to_reg, reg_write, dbg_addr,
    output busy, done, result, zero, dbg_data
  );
endinterface

// File: rtl/mc_alu.sv
// Combinational ALU control decode plus ALU; unknown operations give 0.
module mc_alu
  import mc_datapath_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [1:0]        alu_op,
  input  logic [5:0]        func_code,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] out,
  output logic              zero
);

  logic [3:0] ctl_s;

  // Operation select and zero flag
  always_comb begin
    ctl_s = alu_ctl_f(alu_op, func_code);
    out   = '0;
    case (ctl_s)
      ALUCTL_AND: out = a & b;
      ALUCTL_OR:  out = a | b;
      ALUCTL_ADD: out = a + b;
      ALUCTL_SUB: out = a - b;
      ALUCTL_SLT: out = {{(DATA_W-1){1'b0}}, ($signed(a) < $signed(b))};
      ALUCTL_NOR: out = ~(a | b);
      default:    out = '0;
    endcase
    zero = (out == '0);
  end

endmodule

// File: rtl/multicycle_datapath.sv
// Multi-cycle register/ALU/data-memory datapath: one decoded instruction per
// start, sequenced IDLE->DECODE->EXECUTE->(MEMORY)->(WRITEBACK) with a done pulse.
module multicycle_datapath
  import mc_datapath_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int REG_AW    = 5,
  parameter int MEM_DEPTH = 256
) (
  input logic                  clock,
  input logic                  reset_n,
  multicycle_datapath_if.slave bus
);

  localparam int MEM_AW = $clog2(MEM_DEPTH);
  localparam int NREGS  = 2 ** REG_AW;

  state_e            state_q, state_d;
  ctrl_t             ctrl_q, ctrl_d;
  logic [REG_AW-1:0] rs_q, rs_d, rt_q, rt_d, rd_q, rd_d;
  logic [15:0]       imm_q, imm_d;
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d, rtval_q, rtval_d;
  logic [DATA_W-1:0] alu_out_q, alu_out_d, mdr_q, mdr_d, result_q, result_d;
  logic              zero_q, zero_d, done_q, done_d;

  logic [DATA_W-1:0] rf_q [NREGS];
  logic [DATA_W-1:0] mem_q [MEM_DEPTH];

  logic [DATA_W-1:0] alu_out_s, wb_data_s, rf_wdata_s;
  logic              alu_zero_s, goes_wb_s, rf_we_s, mem_we_s;
  logic [REG_AW-1:0] wb_dest_s, rf_waddr_s;
  logic [MEM_AW-1:0] mem_addr_s;

  mc_alu #(.DATA_W(DATA_W)) u_alu (
    .alu_op    (ctrl_q.alu_op),
    .func_code (ctrl_q.func_code),
    .a         (a_q),
    .b         (b_q),
    .out       (alu_out_s),
    .zero      (alu_zero_s)
  );

  assign wb_dest_s  = ctrl_q.reg_dst ? rd_q : rt_q;
  assign wb_data_s  = ctrl_q.mem_to_reg ? mdr_q : alu_out_q;
  assign mem_addr_s = alu_out_q[MEM_AW+1:2];
  // Stores take priority; a store never writes back.
  assign goes_wb_s  = ctrl_q.mem_write ? 1'b0 : (ctrl_q.mem_read | ctrl_q.reg_write);

  assign bus.busy     = (state_q != ST_IDLE);
  assign bus.done     = done_q;
  assign bus.result   = result_q;
  assign bus.zero     = zero_q;
  assign bus.dbg_data = rf_q[bus.dbg_addr];

  // Next-state and datapath latch control
  always_comb begin
    state_d    = state_q;
    ctrl_d     = ctrl_q;
    rs_d       = rs_q;
    rt_d       = rt_q;
    rd_d       = rd_q;
    imm_d      = imm_q;
    a_d        = a_q;
    b_d        = b_q;
    rtval_d    = rtval_q;
    alu_out_d  = alu_out_q;
    mdr_d      = mdr_q;
    result_d   = result_q;
    zero_d     = zero_q;
    done_d     = 1'b0;
    rf_we_s    = 1'b0;
    rf_waddr_s = wb_dest_s;
    rf_wdata_s = wb_data_s;
    mem_we_s   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          ctrl_d.alu_op     = bus.alu_op;
          ctrl_d.func_code  = bus.func_code;
          ctrl_d.reg_dst    = bus.reg_dst;
          ctrl_d.alu_src    = bus.alu_src;
          ctrl_d.mem_write  = bus.mem_write;
          ctrl_d.mem_read   = bus.mem_read;
          ctrl_d.mem_to_reg = bus.mem_to_reg;
          ctrl_d.reg_write  = bus.reg_write;
          rs_d    = bus.rs;
          rt_d    = bus.rt;
          rd_d    = bus.rd;
          imm_d   = bus.immediate;
          state_d = ST_DECODE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_DECODE: begin
        a_d     = rf_q[rs_q];
        rtval_d = rf_q[rt_q];
        b_d     = ctrl_q.alu_src ? {{(DATA_W-16){imm_q[15]}}, imm_q} : rf_q[rt_q];
        // Compare-only instructions finish in EXECUTE, so done is raised now.
        done_d  = ~(ctrl_q.mem_write | ctrl_q.mem_read | ctrl_q.reg_write);
        state_d = ST_EXECUTE;
      end
      ST_EXECUTE: begin
        alu_out_d = alu_out_s;
        zero_d    = alu_zero_s;
        if (!goes_wb_s) begin
          result_d = alu_out_s;
        end else begin
          result_d = result_q;
        end
        if (ctrl_q.mem_write || ctrl_q.mem_read) begin
          done_d  = ctrl_q.mem_write;
          state_d = ST_MEMORY;
        end else if (ctrl_q.reg_write) begin
          done_d  = 1'b1;
          state_d = ST_WRITEBACK;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_MEMORY: begin
        if (ctrl_q.mem_write) begin
          mem_we_s = 1'b1;
          state_d  = ST_IDLE;
        end else begin
          mdr_d   = mem_q[mem_addr_s];
          done_d  = 1'b1;
          state_d = ST_WRITEBACK;
        end
      end
      ST_WRITEBACK: begin
        rf_we_s  = (wb_dest_s != '0);
        result_d = wb_data_s;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Control and datapath registers
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      ctrl_q    <= '0;
      rs_q      <= '0;
      rt_q      <= '0;
      rd_q      <= '0;
      imm_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      rtval_q   <= '0;
      alu_out_q <= '0;
      mdr_q     <= '0;
      result_q  <= '0;
      zero_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ctrl_q    <= ctrl_d;
      rs_q      <= rs_d;
      rt_q      <= rt_d;
      rd_q      <= rd_d;
      imm_q     <= imm_d;
      a_q       <= a_d;
      b_q       <= b_d;
      rtval_q   <= rtval_d;
      alu_out_q <= alu_out_d;
      mdr_q     <= mdr_d;
      result_q  <= result_d;
      zero_q    <= zero_d;
      done_q    <= done_d;
    end
  end

  // Register file: cleared on reset, register 0 is never written
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      for (int i = 0; i < NREGS; i++) begin
        rf_q[i] <= '0;
      end
    end else if (rf_we_s) begin
      rf_q[rf_waddr_s] <= rf_wdata_s;
    end
  end

  // Data memory keeps its contents through reset; a store is dropped if reset hits
  always_ff @(posedge clock) begin
    if (reset_n && mem_we_s) begin
      mem_q[mem_addr_s] <= rtval_q;
    end
  end

endmodule

// File: tb/tb_multicycle_datapath.sv
// Directed scoreboard bench for multicycle_datapath: latency, result, zero
// and register contents through dbg_addr.
module tb_multicycle_datapath;
  import mc_datapath_pkg::*;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  multicycle_datapath_if #(.DATA_W(32), .REG_AW(5)) bus ();

  multicycle_datapath #(.DATA_W(32), .REG_AW(5), .MEM_DEPTH(256)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct packed {
    logic [4:0]  rs, rt, rd;
    logic [15:0] imm;
    logic [5:0]  funct;
    logic [1:0]  alu_op;
    logic        reg_dst, alu_src, mem_write, mem_read, mem_to_reg, reg_write;
  } instr_t;

  typedef struct {
    int          lat;
    logic [31:0] res;
    logic        zr;
  } exp_t;

  exp_t sb_q[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic instr_t mk(input logic [4:0] rs, rt, rd, input logic [15:0] imm,
                                input logic [5:0] funct, input logic [1:0] op,
                                input logic rdst, asrc, mw, mr, m2r, rw);
    instr_t i;
    i.rs = rs; i.rt = rt; i.rd = rd; i.imm = imm; i.funct = funct; i.alu_op = op;
    i.reg_dst = rdst; i.alu_src = asrc; i.mem_write = mw; i.mem_read = mr;
    i.mem_to_reg = m2r; i.reg_write = rw;
    return i;
  endfunction

  task automatic drive(input instr_t i, input logic st);
    bus.start      = st;
    bus.rs         = i.rs;
    bus.rt         = i.rt;
    bus.rd         = i.rd;
    bus.immediate  = i.imm;
    bus.func_code  = i.funct;
    bus.alu_op     = i.alu_op;
    bus.reg_dst    = i.reg_dst;
    bus.alu_src    = i.alu_src;
    bus.mem_write  = i.mem_write;
    bus.mem_read   = i.mem_read;
    bus.mem_to_reg = i.mem_to_reg;
    bus.reg_write  = i.reg_write;
  endtask

  task automatic chk_reg(input int idx, input logic [31:0] exp);
    bus.dbg_addr = idx[4:0];
    #1;
    check($sformatf("reg%0d", idx), bus.dbg_data, exp);
  endtask

  // Issue from a negedge, measure cycles to done, then check result/zero the cycle after.
  task automatic run(input instr_t i, input int lat, input logic [31:0] res, input logic zr,
                     input bit glitch);
    exp_t e;
    exp_t x;
    int   got;
    e.lat = lat; e.res = res; e.zr = zr;
    sb_q.push_back(e);
    drive(i, 1'b1);
    @(posedge clock);
    #1 bus.start = 1'b0;
    got = 0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clock);
      if (bus.done) begin
        got = c;
        break;
      end
      if (glitch && c == 1) begin
        drive(mk(5'd3, 5'd19, 5'd19, 16'h1234, FUNCT_OR, ALUOP_FUNCT, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1), 1'b1);
      end else begin
        bus.start = 1'b0;
      end
    end
    x = sb_q.pop_front();
    check("latency", got, x.lat);
    @(negedge clock);
    check("done_pulse", {31'd0, bus.done}, 32'd0);
    check("result", bus.result, x.res);
    check("zero", {31'd0, bus.zero}, {31'd0, x.zr});
  endtask

  initial begin
    drive(mk(5'd0, 5'd0, 5'd0, 16'd0, 6'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), 1'b0);
    bus.dbg_addr = 5'd0;
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_done", {31'd0, bus.done}, 32'd0);
    check("rst_result", bus.result, 32'd0);
    check("rst_zero", {31'd0, bus.zero}, 32'd0);
    for (int r = 0; r < 32; r++) chk_reg(r, 32'd0);

    // addi r8 = 5, then add r9 = r8 + r8
    run(mk(5'd0, 5'd8, 5'd0, 16'h0005, 6'd0, ALUOP_ADD, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1), 3, 32'd5, 1'b0, 1'b0);
    run(mk(5'd8, 5'd8, 5'd9, 16'd0, FUNCT_ADD, ALUOP_FUNCT, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1), 3, 32'd10, 1'b0, 1'b0);
    chk_reg(8, 32'd5);
    chk_reg(9, 32'd10);

    // sw r9 -> 0x404 (wraps to word 1), lw r10 <- 0x004
    run(mk(5'd0, 5'd9, 5'd0, 16'h0404, 6'd0, ALUOP_ADD, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0), 3, 32'h404, 1'b0, 1'b0);
    run(mk(5'd0, 5'd10, 5'd0, 16'h0004, 6'd0, ALUOP_ADD, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1), 4, 32'd10, 1'b0, 1'b0);
    chk_reg(10, 32'd10);

    // compare-only sub of equal operands
    run(mk(5'd9, 5'd10, 5'd0, 16'd0, 6'd0, ALUOP_SUB, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), 2, 32'd0, 1'b1, 1'b0);

    // slt positive, addi -1, slt signed negative
    run(mk(5'd8, 5'd9, 5'd11, 16'd0, FUNCT_SLT, ALUOP_FUNCT, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1), 3, 32'd1, 1'b0, 1'b0);
    run(mk(5'd0, 5'd12, 5'd0, 16'hFFFF, 6'd0, ALUOP_ADD, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1), 3, 32'hFFFF_FFFF, 1'b0, 1'b0);
    run(mk(5'd12, 5'd8, 5'd13, 16'd0, FUNCT_SLT, ALUOP_FUNCT, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1), 3, 32'd1, 1'b0, 1'b0);
    chk_reg(11, 32'd1);
    chk_reg(12, 32'hFFFF_FFFF);
    chk_reg(13, 32'd1);

    // write to r0 is discarded
    run(mk(5'd8, 5'd9, 5'd0, 16'd0, FUNCT_ADD, ALUOP_FUNCT, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1), 3, 32'd15, 1'b0, 1'b0);
    chk_reg(0, 32'd0);

    // and, nor, unknown funct, sub wrap
    run(mk(5'd8, 5'd9, 5'd14, 16'd0, FUNCT_AND, ALUOP_FUNCT, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1), 3, 32'd0, 1'b1, 1'b0);
    run(mk(5'd8, 5'd9, 5'd15, 16'd0, FUNCT_NOR, ALUOP_FUNCT, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1), 3, 32'hFFFF_FFF0, 1'b0, 1'b0);
    run(mk(5'd9, 5'd9, 5'd16, 16'd0, 6'h3F, ALUOP_FUNCT, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1), 3, 32'd0, 1'b1, 1'b0);
    run(mk(5'd0, 5'd9, 5'd17, 16'd0, 6'd0, ALUOP_SUB, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1), 3, 32'hFFFF_FFF6, 1'b0, 1'b0);
    chk_reg(15, 32'hFFFF_FFF0);
    chk_reg(16, 32'd0);
    chk_reg(17, 32'hFFFF_FFF6);

    // start pulsed while busy with different fields is ignored
    run(mk(5'd8, 5'd9, 5'd18, 16'd0, FUNCT_OR, ALUOP_FUNCT, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1), 3, 32'd15, 1'b0, 1'b1);
    chk_reg(18, 32'd15);
    chk_reg(19, 32'd0);

    // reset during EXECUTE of sw r12 -> word 1: store abandoned, registers cleared
    drive(mk(5'd0, 5'd12, 5'd0, 16'h0004, 6'd0, ALUOP_ADD, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0), 1'b1);
    @(posedge clock);
    #1 bus.start = 1'b0;
    @(negedge clock);
    check("abort_busy", {31'd0, bus.busy}, 32'd1);
    check("abort_done_c1", {31'd0, bus.done}, 32'd0);
    @(negedge clock);
    check("abort_done_c2", {31'd0, bus.done}, 32'd0);
    reset_n = 1'b0;
    @(negedge clock);
    check("abort_done_c3", {31'd0, bus.done}, 32'd0);
    check("abort_idle", {31'd0, bus.busy}, 32'd0);
    reset_n = 1'b1;
    @(negedge clock);
    check("abort_done_c4", {31'd0, bus.done}, 32'd0);
    check("abort_result", bus.result, 32'd0);
    for (int r = 0; r < 32; r++) chk_reg(r, 32'd0);
    run(mk(5'd0, 5'd10, 5'd0, 16'h0004, 6'd0, ALUOP_ADD, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1), 4, 32'd10, 1'b0, 1'b0);
    chk_reg(10, 32'd10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_datapath.md
Name: multicycle_datapath

Overview:
- Parametrised multi-cycle successor to the single-cycle register/ALU/data-memory datapath.
- Accepts one decoded instruction per start pulse, sequences it through DECODE/EXECUTE/MEMORY/WRITEBACK, and reports completion with a done pulse.
- Sits under the future control FSM or top-level CPU; instruction fields and control bits arrive already decoded.

Parameters:
- DATA_W, 32, datapath, register and memory word width.
- REG_AW, 5, register address width; file holds 2**REG_AW registers.
- MEM_DEPTH, 256, data memory words (power of two).

Ports:
- clock  in  1  rising-edge clock.
- reset_n  in  1  synchronous active-low reset.
- start  in  1  instruction valid; sampled only in IDLE.
- rs, rt, rd  in  REG_AW each  source, target and destination register addresses.
- immediate  in  16  I-type immediate, sign-extended to DATA_W.
- func_code  in  6  R-type funct field.
- alu_op  in  2  operation class: 00 add, 01 sub, 10 use funct.
- reg_dst, alu_src, mem_write, mem_read, mem_to_reg, reg_write  in  1 each  usual MIPS meanings.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse in the final state of an instruction.
- result  out  DATA_W  value written back, or the ALU result if there is no writeback; registered.
- zero  out  1  registered ALU zero flag from EXECUTE.
- dbg_addr  in  REG_AW  debug register read address.
- dbg_data  out  DATA_W  combinational register-file read of dbg_addr.

Behaviour:
- Reset (reset_n low at a clock edge):
  - State goes to IDLE.
  - busy, done, zero = 0 and result = 0.
  - All registers are cleared to 0.
  - Data memory is not reset.
  - Any in-flight instruction is abandoned with no register or memory write.
- IDLE: when start=1, latch all instruction/control inputs, then go to DECODE. While busy, start is ignored and inputs may change freely.
- DECODE: read rs/rt into A/B latches; B_mux = alu_src ? sext(immediate) : reg[rt]; go to EXECUTE.
- EXECUTE: compute the ALU and register ALUOut and zero.
  - If mem_read or mem_write, go to MEMORY.
  - Else if reg_write, go to WRITEBACK.
  - Else assert done and go to IDLE (branch-compare class).
- MEMORY:
  - Word address = ALUOut[log2(MEM_DEPTH)+1:2]. Upper bits are ignored, so addresses wrap modulo the depth; the low 2 bits are ignored.
  - mem_write: write reg[rt] at this edge, assert done, go to IDLE.
  - mem_read: latch MDR, go to WRITEBACK.
- WRITEBACK:
  - Destination = reg_dst ? rd : rt.
  - Write data = mem_to_reg ? MDR : ALUOut.
  - Writes to register 0 are discarded; register 0 always reads 0.
  - Assert done and update result, go to IDLE.
- Latency from the start-sample edge to the done cycle: R-type/addi 3, lw 4, sw 3, compare-only 2. Back-to-back start is legal in the cycle after done.
- Register read during the WRITEBACK edge returns the old value; the new value is visible the next cycle.
- ALU control:
  - Opcodes: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT (signed), 1100 NOR.
  - funct mapping: 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x27 nor, 0x2A slt.
  - Unknown funct gives ALU output 0 and zero=1.
  - Add/sub wrap modulo 2**DATA_W; no overflow flag.
- result holds its value between instructions.

Decomposition:
- Package mc_datapath_pkg holds:
  - the state enum (IDLE, DECODE, EXECUTE, MEMORY, WRITEBACK);
  - the ALUctl constants;
  - the funct constants;
  - the alu_op encodings.
- Sub-module mc_alu: combinational ALU control plus ALU, with inputs alu_op, func_code, A, B and outputs out, zero.
- The register file and memory stay inline as arrays.

Test Plan:
- Reset, then read registers via dbg_addr 0..31 -> all dbg_data = 0; busy=0, done=0.
- addi-style (alu_op=00, alu_src=1, reg_write=1, rs=0, rt=8, imm=0x0005), then R-type add rs=8 rt=8 rd=9 funct=0x20 -> reg9 = 10; done exactly 3 cycles after each start; result=10.
- sw rt=9 base rs=0 imm=0x0404 (MEM_DEPTH=256, wraps to word 1), then lw rt=10 imm=0x0004 -> reg10=10; lw done at cycle 4.
- sub with equal operands (alu_op=01, rs=9, rt=10, no writes) -> done at cycle 2, zero=1; slt reg8(5) vs reg9(10) -> result 1; write to rd=0 -> reg0 stays 0.
- start pulsed during busy with different fields -> ignored; registers match single-instruction expectation.
- reset_n low during EXECUTE of an sw -> state IDLE next cycle, no memory write (later lw returns the old value), all registers 0, done never pulses.
